dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the pipeline M stage and a program/data loader (boot load, debug poke/peek).
- Sits between the execute-mem buffer outputs and the M memory block.
- The pipeline has priority. The loader gets the port on pipeline idle cycles, or forcibly after a starvation limit.
- While the loader owns the port, the arbiter stalls the pipeline M stage.

---
 rtl/dmem_arbiter_pkg.sv | 32 +++
 rtl/dmem_arbiter_sat_counter.sv | 36 +++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared types.
// Owner encoding, request/response bundles, counter ops.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_LOAD = 1'b1
    } ArbOwner;

    typedef struct packed {
        logic                   req;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } ArbReq;

    typedef struct packed {
        logic                   rvalid;
        logic [DMEM_DATA_W-1:0] rdata;
    } ArbRsp;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_CLR  = 2'd1,
        CNT_ONE  = 2'd2,
        CNT_INC  = 2'd3
    } cnt_op_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear / load-one / increment ops.
// Used for both the loader wait count and the burst beat count.
module dmem_arbiter_sat_counter
    import dmem_arbiter_pkg::*;
#(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  cnt_op_e      op,
    output logic [W-1:0] cnt_q
);

    localparam logic [W-1:0] LIM = W'(MAX);

    logic [W-1:0] cnt_d;

    // Next count: saturate at LIM on increment.
    always_comb begin
        cnt_d = cnt_q;
        case (op)
            CNT_CLR: cnt_d = '0;
            CNT_ONE: cnt_d = W'(1);
            CNT_INC: cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline M stage vs program/data loader.
// Pipeline has priority; loader gets idle cycles or is forced after starving.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_WAIT  = 8,
    parameter int BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
    localparam logic [BEAT_W-1:0] BEAT_LIM = BEAT_W'(BURST_MAX);

    ArbOwner           owner_q;
    ArbOwner           owner_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    cnt_op_e           wait_op;
    cnt_op_e           beat_op;
    logic              serve_p;
    logic              serve_l;
    logic              wait_full;
    logic              beat_full;
    logic [1:0]        rd_pend_q;
    logic [1:0]        rd_pend_d;

    assign wait_full = (wait_cnt_q == WAIT_LIM);
    assign beat_full = (beat_cnt_q == BEAT_LIM);

    // Pick the served requester and the next owner / counter ops.
    always_comb begin
        serve_p = 1'b0;
        serve_l = 1'b0;
        owner_d = owner_q;
        wait_op = CNT_HOLD;
        beat_op = CNT_HOLD;
        if (!rst) begin
            case (owner_q)
                OWN_PIPE: begin
                    if (l_req && (!p_req || wait_full)) begin
                        serve_l = 1'b1;
                        owner_d = OWN_LOAD;
                        beat_op = CNT_ONE;
                        wait_op = CNT_CLR;
                    end else if (p_req) begin
                        serve_p = 1'b1;
                        wait_op = l_req ? CNT_INC : CNT_CLR;
                    end else begin
                        wait_op = CNT_CLR;
                    end
                end
                OWN_LOAD: begin
                    if (l_req && !(p_req && beat_full)) begin
                        serve_l = 1'b1;
                        beat_op = CNT_INC;
                    end else begin
                        serve_p = p_req;
                        owner_d = OWN_PIPE;
                        beat_op = CNT_CLR;
                        wait_op = l_req ? CNT_ONE : CNT_CLR;
                    end
                end
                default: owner_d = OWN_PIPE;
            endcase
        end
    end

    // Memory command mux, handshakes and read-return qualifiers.
    always_comb begin
        mem_en    = serve_p | serve_l;
        mem_we    = serve_l ? l_we : (serve_p & p_we);
        mem_addr  = serve_l ? l_addr : p_addr;
        mem_wdata = serve_l ? l_wdata : p_wdata;
        l_gnt     = serve_l;
        p_stall   = p_req & ~serve_p & ~rst;
        p_rvalid  = rd_pend_q[1] & ~rst;
        l_rvalid  = rd_pend_q[0] & ~rst;
        p_rdata   = mem_rdata;
        l_rdata   = mem_rdata;
        rd_pend_d = {serve_p & ~p_we, serve_l & ~l_we};
    end

    // Owner and read-pending registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_PIPE;
            rd_pend_q <= '0;
        end else begin
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    dmem_arbiter_sat_counter #(
        .MAX (MAX_WAIT),
        .W   (WAIT_W)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .op    (wait_op),
        .cnt_q (wait_cnt_q)
    );

    dmem_arbiter_sat_counter #(
        .MAX (BURST_MAX),
        .W   (BEAT_W)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .op    (beat_op),
        .cnt_q (beat_cnt_q)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic
// checked against a rule-level arbitration and memory model.
module tb_dmem_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int MAX_WAIT  = 8;
    localparam int BURST_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          p_req, p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic          p_stall, p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          l_req, l_we;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata;
    logic          l_gnt, l_rvalid;
    logic [DW-1:0] l_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .p_req     (p_req),
        .p_we      (p_we),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_stall   (p_stall),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_gnt     (l_gnt),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory attached to the arbiter (one registered read cycle).
    logic [DW-1:0] mem [256];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state.
    bit            m_load;
    int            m_wait, m_beats;
    bit            pend_p, pend_l;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] shadow [256];

    logic [5:0]    exp_vec;
    bit            exp_en, exp_we, exp_gnt, exp_stall, exp_prv, exp_lrv;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [5:0] obs_vec();
        return {p_stall, l_gnt, mem_en, mem_en & mem_we, p_rvalid, l_rvalid};
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        return (a == 'h10) ? 32'hDEADBEEF : (32'hA5000000 | 32'(a * 7));
    endfunction

    // Apply one cycle of stimulus; model computes what must happen.
    task automatic drive_cycle(
        input logic          r,
        input logic          pr, input logic pw,
        input logic [AW-1:0] pa, input logic [DW-1:0] pd,
        input logic          lr, input logic lw,
        input logic [AW-1:0] la, input logic [DW-1:0] ld
    );
        int who;
        @(negedge clk);
        rst = r;
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
        exp_prv   = !r && pend_p;
        exp_lrv   = !r && pend_l;
        exp_rdata = pend_data;
        who = 0;
        if (r) begin
            m_load = 0; m_wait = 0; m_beats = 0;
        end else if (!m_load) begin
            if (lr && (!pr || m_wait == MAX_WAIT)) begin
                who = 2; m_load = 1; m_beats = 1; m_wait = 0;
            end else if (pr) begin
                who = 1;
                m_wait = !lr ? 0 : (m_wait < MAX_WAIT ? m_wait + 1 : MAX_WAIT);
            end else begin
                m_wait = 0;
            end
        end else begin
            if (lr && !(pr && m_beats == BURST_MAX)) begin
                who = 2;
                m_beats = (m_beats < BURST_MAX) ? m_beats + 1 : BURST_MAX;
            end else begin
                who = pr ? 1 : 0;
                m_load = 0; m_beats = 0; m_wait = lr ? 1 : 0;
            end
        end
        exp_en    = (who != 0);
        exp_gnt   = (who == 2);
        exp_stall = !r && pr && (who != 1);
        exp_we    = (who == 1) ? pw : (who == 2) ? lw : 1'b0;
        exp_addr  = (who == 2) ? la : pa;
        exp_wdata = (who == 2) ? ld : pd;
        pend_p    = (who == 1) && !pw;
        pend_l    = (who == 2) && !lw;
        if (exp_en && !exp_we) pend_data = shadow[exp_addr];
        if (exp_en && exp_we)  shadow[exp_addr] = exp_wdata;
        exp_vec = {exp_stall, exp_gnt, exp_en, exp_en & exp_we, exp_prv, exp_lrv};
        #2;
    endtask

    task automatic idle();
        drive_cycle(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1, 1'($urandom), 1'($urandom), 8'($urandom), $urandom,
                        1'($urandom), 1'($urandom), 8'($urandom), $urandom);
            n_vec++;
            if (obs_vec() !== 6'b0) begin
                n_err++;
                $display("FAIL reset_outputs: got %b want 000000", obs_vec());
            end
        end
    endtask

    task automatic test_pipe_read();
        drive_cycle(0, 1, 0, 8'h10, '0, 0, 0, '0, '0);
        n_vec++;
        if (p_stall !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h10) begin
            n_err++;
            $display("FAIL pipe_read_cmd: stall=%b en=%b addr=%h want 0 1 10",
                     p_stall, mem_en, mem_addr);
        end
        idle();
        n_vec++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF || l_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL pipe_read_ret: prv=%b data=%h lrv=%b want 1 deadbeef 0",
                     p_rvalid, p_rdata, l_rvalid);
        end
    endtask

    task automatic test_loader_burst();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(0, 0, 0, '0, '0, 1, 1, 8'(8'h20 + i), 32'hC0DE0000 + 32'(i));
            n_vec++;
            if (l_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 ||
                mem_addr !== 8'(8'h20 + i)) begin
                n_err++;
                $display("FAIL load_beat%0d: gnt=%b en=%b we=%b addr=%h want 1 1 1 %h",
                         i, l_gnt, mem_en, mem_we, mem_addr, 8'(8'h20 + i));
            end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (mem[8'h20 + i] !== 32'hC0DE0000 + 32'(i)) begin
                n_err++;
                $display("FAIL load_mem%0d: got %h want %h",
                         i, mem[8'h20 + i], 32'hC0DE0000 + 32'(i));
            end
        end
        drive_cycle(0, 1, 0, 8'h40, '0, 1, 0, 8'h41, '0);
        n_vec++;
        if (p_stall !== 1'b0 || l_gnt !== 1'b0 || mem_addr !== 8'h40) begin
            n_err++;
            $display("FAIL load_owner_back: stall=%b gnt=%b addr=%h want 0 0 40",
                     p_stall, l_gnt, mem_addr);
        end
        idle();
    endtask

    task automatic test_starvation();
        logic st_w, gn_w;
        for (int i = 0; i < 13; i++) begin
            drive_cycle(0, 1, 0, 8'h50, '0, 1, 0, 8'h60, '0);
            st_w = (i >= MAX_WAIT && i < MAX_WAIT + BURST_MAX);
            gn_w = st_w;
            n_vec++;
            if (p_stall !== st_w || l_gnt !== gn_w ||
                mem_addr !== (gn_w ? 8'h60 : 8'h50)) begin
                n_err++;
                $display("FAIL starve_cyc%0d: stall=%b gnt=%b addr=%h want %b %b",
                         i, p_stall, l_gnt, mem_addr, st_w, gn_w);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_burst_drop();
        drive_cycle(0, 0, 0, '0, '0, 1, 1, 8'h70, 32'h70);
        drive_cycle(0, 1, 1, 8'h72, 32'h72, 1, 1, 8'h71, 32'h71);
        n_vec++;
        if (l_gnt !== 1'b1 || p_stall !== 1'b1) begin
            n_err++;
            $display("FAIL burst_beat2: gnt=%b stall=%b want 1 1", l_gnt, p_stall);
        end
        drive_cycle(0, 1, 1, 8'h72, 32'h72, 0, 0, '0, '0);
        n_vec++;
        if (p_stall !== 1'b0 || l_gnt !== 1'b0 || mem_en !== 1'b1 ||
            mem_addr !== 8'h72) begin
            n_err++;
            $display("FAIL burst_drop: stall=%b gnt=%b en=%b addr=%h want 0 0 1 72",
                     p_stall, l_gnt, mem_en, mem_addr);
        end
        idle();
    endtask

    task automatic test_reset_read();
        drive_cycle(0, 0, 0, '0, '0, 1, 0, 8'h05, '0);
        drive_cycle(1, 0, 0, '0, '0, 0, 0, '0, '0);
        n_vec++;
        if (l_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_read_drop: lrv=%b en=%b want 0 0", l_rvalid, mem_en);
        end
        idle();
        n_vec++;
        if (l_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_read_after: lrv=%b want 0", l_rvalid);
        end
        for (int i = 0; i <= MAX_WAIT; i++) begin
            drive_cycle(0, 1, 0, 8'h01, '0, 1, 0, 8'h02, '0);
            n_vec++;
            if (l_gnt !== (i == MAX_WAIT) || p_stall !== (i == MAX_WAIT)) begin
                n_err++;
                $display("FAIL rst_cnt_cyc%0d: gnt=%b stall=%b want %b",
                         i, l_gnt, p_stall, i == MAX_WAIT);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_back_to_back();
        drive_cycle(0, 1, 1, 8'h30, 32'h1234, 0, 0, '0, '0);
        n_vec++;
        if (p_rvalid !== 1'b0 || mem_we !== 1'b1) begin
            n_err++;
            $display("FAIL raw_write: prv=%b we=%b want 0 1", p_rvalid, mem_we);
        end
        drive_cycle(0, 0, 0, '0, '0, 1, 0, 8'h30, '0);
        n_vec++;
        if (l_gnt !== 1'b1 || p_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL raw_issue: gnt=%b prv=%b want 1 0", l_gnt, p_rvalid);
        end
        idle();
        n_vec++;
        if (l_rvalid !== 1'b1 || l_rdata !== 32'h1234 || p_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL raw_return: lrv=%b data=%h prv=%b want 1 00001234 0",
                     l_rvalid, l_rdata, p_rvalid);
        end
    endtask

    task automatic test_random();
        int lwait_run = 0;
        int pstall_run = 0;
        for (int n = 0; n < 3000; n++) begin
            drive_cycle($urandom_range(0, 99) == 0,
                        $urandom_range(0, 9) < 6, 1'($urandom),
                        8'($urandom_range(0, 15)), $urandom,
                        $urandom_range(0, 9) < 5, 1'($urandom),
                        8'($urandom_range(0, 15)), $urandom);
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++;
                $display("FAIL rnd_ctl@%0d: got %b want %b", n, obs_vec(), exp_vec);
            end
            if (exp_en) begin
                n_vec++;
                if (mem_addr !== exp_addr || (exp_we && mem_wdata !== exp_wdata)) begin
                    n_err++;
                    $display("FAIL rnd_cmd@%0d: addr=%h wd=%h want %h %h",
                             n, mem_addr, mem_wdata, exp_addr, exp_wdata);
                end
            end
            if (exp_prv || exp_lrv) begin
                n_vec++;
                if ((exp_prv ? p_rdata : l_rdata) !== exp_rdata) begin
                    n_err++;
                    $display("FAIL rnd_rdata@%0d: got %h want %h",
                             n, exp_prv ? p_rdata : l_rdata, exp_rdata);
                end
            end
            lwait_run  = (!rst && l_req && !l_gnt) ? lwait_run + 1 : 0;
            pstall_run = (!rst && p_req && p_stall) ? pstall_run + 1 : 0;
            n_vec++;
            if (lwait_run > MAX_WAIT + 1 || pstall_run > BURST_MAX) begin
                n_err++;
                $display("FAIL rnd_bound@%0d: lwait=%0d pstall=%0d limits %0d %0d",
                         n, lwait_run, pstall_run, MAX_WAIT + 1, BURST_MAX);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        m_load = 0; m_wait = 0; m_beats = 0;
        pend_p = 0; pend_l = 0; pend_data = '0;
        for (int a = 0; a < 256; a++) begin
            shadow[a] = init_word(a);
            @(negedge clk);
            bd_we = 1'b1; bd_addr = 8'(a); bd_data = init_word(a);
        end
        @(negedge clk);
        bd_we = 1'b0;
        test_reset();
        test_pipe_read();
        test_loader_burst();
        test_starvation();
        test_burst_drop();
        test_reset_read();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
